// File: rtl/bcd_pkg.sv
// Shared definitions for the four-digit BCD counter and its display scanner.
//   bcd_digit_t  : one packed BCD digit (0..9 legal)
//   BCD_MAX      : largest legal digit value
//   NUM_DIGITS   : digits in the counter
//   scan_state_t : display scan position, one state per digit
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_t;

endpackage

// File: rtl/bcd_digit_cell.sv
// Single BCD digit step logic (purely combinational).
//   digit      : current digit value
//   step       : counter enable for this cycle
//   up         : 1 = increment, 0 = decrement
//   carry_in   : lower digits rolled over (tie high for digit 0)
//   next_digit : digit value after this cycle's step
//   carry_out  : this digit rolls over (9->0 up, 0->9 down)
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       step,
    input  logic       up,
    input  logic       carry_in,
    output bcd_digit_t next_digit,
    output logic       carry_out
);

    logic active;
    logic at_limit;

    // A digit only moves when the whole chain below it is rolling over.
    assign active   = step & carry_in;
    assign at_limit = up ? (digit == BCD_MAX) : (digit == 4'd0);

    always_comb begin
        next_digit = digit;
        if (active) begin
            if (up) next_digit = at_limit ? 4'd0    : bcd_digit_t'(digit + 4'd1);
            else    next_digit = at_limit ? BCD_MAX : bcd_digit_t'(digit - 4'd1);
        end
    end

    assign carry_out = active & at_limit;

endmodule

// File: rtl/bcd_counter.sv
// Four-digit BCD up/down counter with load and a multiplexed display scanner.
//   cnt_clk       : clock, rising edge
//   cnt_rst       : synchronous active-high reset
//   cnt_en        : count one step this cycle
//   cnt_up        : 1 = up, 0 = down
//   cnt_load      : load cnt_load_val (wins over cnt_en)
//   cnt_load_val  : four BCD digits, [3:0] = digit 0
//   cnt_value     : registered counter value
//   cnt_wrap      : one-cycle pulse after 9999->0000 or 0000->9999
//   cnt_load_err  : one-cycle pulse after a load with a non-BCD digit
//   cnt_bcd_out   : digit currently being displayed
//   cnt_digit_sel : one-hot display position enable
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        cnt_clk,
    input  logic        cnt_rst,
    input  logic        cnt_en,
    input  logic        cnt_up,
    input  logic        cnt_load,
    input  logic [15:0] cnt_load_val,
    output logic [15:0] cnt_value,
    output logic        cnt_wrap,
    output logic        cnt_load_err,
    output logic [3:0]  cnt_bcd_out,
    output logic [3:0]  cnt_digit_sel
);

    localparam int                DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    // ---------------- counter datapath ----------------
    logic [NUM_DIGITS:0]            carry;
    bcd_digit_t [NUM_DIGITS-1:0]    nxt;
    logic                           load_ok;

    assign carry[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_cell u_cell (
                .digit      (cnt_value[4*g +: 4]),
                .step       (cnt_en),
                .up         (cnt_up),
                .carry_in   (carry[g]),
                .next_digit (nxt[g]),
                .carry_out  (carry[g+1])
            );
        end
    endgenerate

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_load_val[4*i +: 4] > BCD_MAX) load_ok = 1'b0;
        end
    end

    always_ff @(posedge cnt_clk) begin
        if (cnt_rst) begin
            cnt_value    <= '0;
            cnt_wrap     <= 1'b0;
            cnt_load_err <= 1'b0;
        end else begin
            cnt_wrap     <= 1'b0;
            cnt_load_err <= 1'b0;
            if (cnt_load) begin
                if (load_ok) cnt_value    <= cnt_load_val;
                else         cnt_load_err <= 1'b1;
            end else if (cnt_en) begin
                cnt_value <= nxt;
                // Carry out of the top digit means the whole counter rolled over.
                cnt_wrap  <= carry[NUM_DIGITS];
            end
        end
    end

    // ---------------- display scanner ----------------
    logic [DIV_W-1:0] scan_div;
    scan_state_t      scan_state;

    always_ff @(posedge cnt_clk) begin
        if (cnt_rst) begin
            scan_div      <= '0;
            scan_state    <= DIG0;
            cnt_digit_sel <= 4'b0001;
        end else if (scan_div == DIV_LAST) begin
            scan_div <= '0;
            case (scan_state)
                DIG0: begin scan_state <= DIG1; cnt_digit_sel <= 4'b0010; end
                DIG1: begin scan_state <= DIG2; cnt_digit_sel <= 4'b0100; end
                DIG2: begin scan_state <= DIG3; cnt_digit_sel <= 4'b1000; end
                default: begin scan_state <= DIG0; cnt_digit_sel <= 4'b0001; end
            endcase
        end else begin
            scan_div <= scan_div + DIV_W'(1);
        end
    end

    // Selected digit follows the registered value in the same cycle.
    always_comb begin
        cnt_bcd_out = cnt_value[3:0];
        case (scan_state)
            DIG0:    cnt_bcd_out = cnt_value[3:0];
            DIG1:    cnt_bcd_out = cnt_value[7:4];
            DIG2:    cnt_bcd_out = cnt_value[11:8];
            default: cnt_bcd_out = cnt_value[15:12];
        endcase
    end

endmodule

// File: doc/bcd_counter.md
BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per display digit slot, legal range 2..2^20.
REQ-002 SHALL have port cnt_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port cnt_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cnt_en, input, 1 bit: count tick; one step per cycle while high.
REQ-005 SHALL have port cnt_up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port cnt_load, input, 1 bit: synchronous load request.
REQ-007 SHALL have port cnt_load_val, input, 16 bits: four BCD digits; [3:0] is digit 0 (least significant).
REQ-008 SHALL have port cnt_value, output, 16 bits: registered counter value, same packing as cnt_load_val.
REQ-009 SHALL have port cnt_wrap, output, 1 bit: registered one-cycle pulse on a wrap-around.
REQ-010 SHALL have port cnt_load_err, output, 1 bit: registered one-cycle pulse when a load is rejected.
REQ-011 SHALL have port cnt_bcd_out, output, 4 bits: currently scanned digit; drives the downstream 7-segment decoder input.
REQ-012 SHALL have port cnt_digit_sel, output, 4 bits: one-hot, active-high enable of the scanned display position.

Function
REQ-013 Counter range SHALL be 0000..9999 decimal, with every digit held in the range 0..9 at all times.
REQ-014 Priority per cycle SHALL be: reset, then load, then count; load and cnt_en high together SHALL load and not count.
REQ-015 Load SHALL take effect on the next edge; if any digit of cnt_load_val exceeds 9, cnt_value SHALL be held, cnt_load_err SHALL pulse, and cnt_wrap SHALL stay 0.
REQ-016 Up count SHALL increment digit 0; a digit at 9 SHALL go to 0 and carry into the next digit; the full ripple SHALL resolve within one cycle.
REQ-017 Down count SHALL decrement digit 0; a digit at 0 SHALL go to 9 and borrow from the next digit; the full ripple SHALL resolve within one cycle.
REQ-018 9999 up SHALL produce 0000, and 0000 down SHALL produce 9999; cnt_wrap SHALL be 1 in the cycle after the wrapping edge only.
REQ-019 Direction changes SHALL take effect on the next enabled tick with no lost or extra step.
REQ-020 Scan divider SHALL count 0..SCAN_DIV-1 continuously, independent of cnt_en and cnt_load; on its terminal count the scan state SHALL advance.
REQ-021 Scan FSM states SHALL be DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0; cnt_digit_sel SHALL be 0001, 0010, 0100, 1000 respectively.
REQ-022 cnt_bcd_out SHALL equal the digit of the registered cnt_value selected by the current scan state, combinationally in the same cycle.
REQ-023 cnt_digit_sel SHALL always be exactly one-hot; a value change SHALL appear on cnt_bcd_out in the cycle after the updating edge.

Reset
REQ-024 While cnt_rst is high at an edge: cnt_value SHALL become 0000, cnt_wrap 0, cnt_load_err 0, scan divider 0, scan state DIG0 (cnt_digit_sel = 0001, cnt_bcd_out = 0).
REQ-025 Reset asserted mid-count or mid-load SHALL discard the pending operation; counting SHALL resume on the first edge after cnt_rst falls.

Structure
REQ-026 Shared package bcd_pkg SHALL hold typedef bcd_digit_t (4 bits), constant BCD_MAX = 9, constant NUM_DIGITS = 4, and the scan state enum.
REQ-027 One sub-module, bcd_digit_cell, SHALL implement a single digit: inputs step, up, carry_in; outputs next digit, carry_out. It SHALL be instantiated NUM_DIGITS times.
REQ-028 cnt_bcd_out SHALL connect directly to the 7-segment decoder input with no extra logic.

Verification (bench uses SCAN_DIV = 4)
REQ-029 Reset, then cnt_en = 1, cnt_up = 1 for 12 cycles -> cnt_value = 0012, cnt_wrap never 1.
REQ-030 Load 9998, then 2 up ticks -> values 9999, then 0000, with cnt_wrap = 1 for exactly one cycle; 1 down tick from 0000 -> 9999, with cnt_wrap pulse.
REQ-031 Load 0x12A4 -> cnt_load_err pulses once and cnt_value is unchanged; load together with cnt_en -> loaded value, no step.
REQ-032 Hold value 1234 for 16 cycles -> cnt_digit_sel steps 0001/0010/0100/1000, 4 cycles each, with cnt_bcd_out 4, 3, 2, 1.
REQ-033 Assert cnt_rst during count at 0457 in scan state DIG2 -> next cycle shows cnt_value 0000, cnt_digit_sel 0001, cnt_bcd_out 0.
